// File: rtl/clause_feeder.sv
// Producer side of the unit-clause evaluation interface: fetches one clause record,
// looks up each literal's variable and presents the assembled vectors with sat/conflict flags.
`ifndef VAR_PER_CLAUSE
`define VAR_PER_CLAUSE 5
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

// state   | meaning
// IDLE    | waiting for start
// CLS_RD  | clause memory read issued
// CLS_CAP | clause record captured, accumulators cleared
// SCAN    | one variable lookup per literal, previous lookup folded in
// VWAIT   | last lookup folded in, conflict resolved
// OUT     | result presented until out_ready
module clause_feeder #(
    parameter int VPC = `VAR_PER_CLAUSE,
    parameter int VB  = `MAX_VARS_BITS,
    parameter int CB  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CB-1:0]     start_idx,
    output logic              busy,
    output logic              cls_rd_en,
    output logic [CB-1:0]     cls_rd_addr,
    input  logic [VPC-1:0]    cls_rd_mask,
    input  logic [VPC-1:0]    cls_rd_pole,
    input  logic [VPC*VB-1:0] cls_rd_var,
    output logic              var_rd_en,
    output logic [VB-1:0]     var_rd_addr,
    input  logic              var_rd_assigned,
    input  logic              var_rd_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VPC-1:0]    unassign,
    output logic [VPC-1:0]    clause_mask,
    output logic [VPC-1:0]    clause_pole,
    output logic [VPC*VB-1:0] variable,
    output logic              clause_sat,
    output logic              clause_conflict
);

    localparam int KW = (VPC > 1) ? $clog2(VPC) : 1;

    typedef enum logic [2:0] {IDLE, CLS_RD, CLS_CAP, SCAN, VWAIT, OUT} state_t;

    state_t         state, state_nxt;
    logic [CB-1:0]  idx_q;
    logic [KW-1:0]  k;
    logic           proc_en;
    logic [KW-1:0]  proc_j;
    logic [VPC-1:0] unassign_nxt;
    logic           sat_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        cls_rd_en   = 1'b0;
        cls_rd_addr = '0;
        var_rd_en   = 1'b0;
        var_rd_addr = '0;
        out_valid   = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = CLS_RD;
            CLS_RD: begin
                cls_rd_en   = 1'b1;
                cls_rd_addr = idx_q;
                state_nxt   = CLS_CAP;
            end
            CLS_CAP: state_nxt = SCAN;
            SCAN: begin
                // masked-off literals still take their slot so latency never varies
                var_rd_en   = clause_mask[k];
                var_rd_addr = variable[int'(k)*VB +: VB];
                if (k == KW'(VPC-1)) state_nxt = VWAIT;
            end
            VWAIT:   state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // lookup data arrives one cycle behind its request, so SCAN slot k folds in literal k-1
    always_comb begin
        proc_en      = 1'b0;
        proc_j       = '0;
        unassign_nxt = unassign;
        sat_nxt      = clause_sat;
        if (state == SCAN && k != '0) begin
            proc_en = 1'b1;
            proc_j  = k - KW'(1);
        end else if (state == VWAIT) begin
            proc_en = 1'b1;
            proc_j  = KW'(VPC-1);
        end
        if (proc_en) begin
            if (clause_mask[proc_j]) begin
                unassign_nxt[proc_j] = ~var_rd_assigned;
                if (var_rd_assigned && (var_rd_value != clause_pole[proc_j])) sat_nxt = 1'b1;
            end else begin
                unassign_nxt[proc_j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q           <= '0;
            k               <= '0;
            clause_mask     <= '0;
            clause_pole     <= '0;
            variable        <= '0;
            unassign        <= '0;
            clause_sat      <= 1'b0;
            clause_conflict <= 1'b0;
        end else begin
            if (state == IDLE && start) idx_q <= start_idx;
            if (state == CLS_CAP) begin
                clause_mask     <= cls_rd_mask;
                clause_pole     <= cls_rd_pole;
                variable        <= cls_rd_var;
                unassign        <= '0;
                clause_sat      <= 1'b0;
                clause_conflict <= 1'b0;
                k               <= '0;
            end else if (state == SCAN) begin
                unassign   <= unassign_nxt;
                clause_sat <= sat_nxt;
                if (k != KW'(VPC-1)) k <= k + KW'(1);
                else                 k <= '0;
            end else if (state == VWAIT) begin
                unassign        <= unassign_nxt;
                clause_sat      <= sat_nxt;
                clause_conflict <= (clause_mask != '0) && (unassign_nxt == '0) && !sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_clause_feeder.sv
// Bench for clause_feeder: clause memory and assignment table models, a clause-level
// reference model, a per-cycle compare process, directed cases and randomized traffic.
module tb_clause_feeder;

    localparam int VPC = 5;
    localparam int VB  = 8;
    localparam int CB  = 10;
    localparam int NV  = 1 << VB;
    localparam int NC  = 1 << CB;
    localparam int LAT = VPC + 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [CB-1:0]     start_idx;
    logic              busy;
    logic              cls_rd_en;
    logic [CB-1:0]     cls_rd_addr;
    logic [VPC-1:0]    cls_rd_mask;
    logic [VPC-1:0]    cls_rd_pole;
    logic [VPC*VB-1:0] cls_rd_var;
    logic              var_rd_en;
    logic [VB-1:0]     var_rd_addr;
    logic              var_rd_assigned;
    logic              var_rd_value;
    logic              out_valid;
    logic              out_ready;
    logic [VPC-1:0]    unassign;
    logic [VPC-1:0]    clause_mask;
    logic [VPC-1:0]    clause_pole;
    logic [VPC*VB-1:0] variable;
    logic              clause_sat;
    logic              clause_conflict;

    clause_feeder #(.VPC(VPC), .VB(VB), .CB(CB)) dut (
        .clock(clock), .reset(reset), .start(start), .start_idx(start_idx), .busy(busy),
        .cls_rd_en(cls_rd_en), .cls_rd_addr(cls_rd_addr), .cls_rd_mask(cls_rd_mask),
        .cls_rd_pole(cls_rd_pole), .cls_rd_var(cls_rd_var), .var_rd_en(var_rd_en),
        .var_rd_addr(var_rd_addr), .var_rd_assigned(var_rd_assigned), .var_rd_value(var_rd_value),
        .out_valid(out_valid), .out_ready(out_ready), .unassign(unassign),
        .clause_mask(clause_mask), .clause_pole(clause_pole), .variable(variable),
        .clause_sat(clause_sat), .clause_conflict(clause_conflict)
    );

    always #5 clock = ~clock;

    logic [VPC-1:0]    cm [NC];
    logic [VPC-1:0]    cp [NC];
    logic [VPC*VB-1:0] cv [NC];
    logic              va [NV];
    logic              vv [NV];

    // memories answer one cycle after the enable; junk otherwise so stray reads show up
    always @(posedge clock) begin
        if (cls_rd_en) begin
            cls_rd_mask <= cm[cls_rd_addr];
            cls_rd_pole <= cp[cls_rd_addr];
            cls_rd_var  <= cv[cls_rd_addr];
        end else begin
            cls_rd_mask <= VPC'($urandom);
            cls_rd_pole <= VPC'($urandom);
            cls_rd_var  <= (VPC*VB)'({$urandom, $urandom});
        end
        if (var_rd_en) begin
            var_rd_assigned <= va[var_rd_addr];
            var_rd_value    <= vv[var_rd_addr];
        end else begin
            var_rd_assigned <= 1'($urandom);
            var_rd_value    <= 1'($urandom);
        end
    end

    typedef struct packed {
        logic [VPC-1:0]    mask;
        logic [VPC-1:0]    pole;
        logic [VPC*VB-1:0] vars;
        logic [VPC-1:0]    un;
        logic              sat;
        logic              conf;
    } res_t;

    function automatic res_t calc(input int idx);
        res_t r;
        int   n_act, n_asg, v;
        n_act  = 0;
        n_asg  = 0;
        r.mask = cm[idx];
        r.pole = cp[idx];
        r.vars = cv[idx];
        r.un   = '0;
        r.sat  = 1'b0;
        for (int j = 0; j < VPC; j++) begin
            if (r.mask[j]) begin
                v = int'(r.vars[j*VB +: VB]);
                n_act++;
                if (!va[v]) r.un[j] = 1'b1;
                else begin
                    n_asg++;
                    if (vv[v] != r.pole[j]) r.sat = 1'b1;
                end
            end
        end
        r.conf = (n_act > 0) && (n_asg == n_act) && !r.sat;
        return r;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // clause-level model: one op = accept edge, LAT edges to result, then wait for ready
    bit            m_busy = 1'b0;
    int            m_cnt  = 0;
    logic [CB-1:0] m_idx  = '0;
    res_t          cur    = '0;
    res_t          held   = '0;
    int            rd_pulses = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_idx  = '0;
            cur    = '0;
            held   = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_idx  = start_idx;
                cur    = calc(int'(start_idx));
            end
        end else if (m_cnt >= LAT) begin
            if (out_ready) begin
                m_busy = 1'b0;
                held   = cur;
            end
        end else begin
            m_cnt++;
        end
    end

    int kslot;
    bit in_scan;

    always @(negedge clock) begin
        in_scan = m_busy && m_cnt >= 2 && m_cnt <= VPC + 1;
        kslot   = in_scan ? m_cnt - 2 : 0;
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_busy && m_cnt >= LAT);
        chk("cls_rd_en", cls_rd_en, m_busy && m_cnt == 0);
        if (cls_rd_en) chk("cls_rd_addr", cls_rd_addr, m_idx);
        chk("var_rd_en", var_rd_en, in_scan && cur.mask[kslot]);
        if (var_rd_en && in_scan) chk("var_rd_addr", var_rd_addr, cur.vars[kslot*VB +: VB]);
        if (var_rd_en) rd_pulses++;
        if (!m_busy || m_cnt <= 1) begin
            chk("held.mask", clause_mask, held.mask);
            chk("held.pole", clause_pole, held.pole);
            chk("held.vars", variable, held.vars);
            chk("held.unassign", unassign, held.un);
            chk("held.sat", clause_sat, held.sat);
            chk("held.conflict", clause_conflict, held.conf);
        end else if (m_cnt >= LAT) begin
            chk("res.mask", clause_mask, cur.mask);
            chk("res.pole", clause_pole, cur.pole);
            chk("res.vars", variable, cur.vars);
            chk("res.unassign", unassign, cur.un);
            chk("res.sat", clause_sat, cur.sat);
            chk("res.conflict", clause_conflict, cur.conf);
        end else begin
            chk("cap.mask", clause_mask, cur.mask);
            chk("cap.pole", clause_pole, cur.pole);
            chk("cap.vars", variable, cur.vars);
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic do_op(input int idx, output int lat);
        @(negedge clock);
        start     = 1'b1;
        start_idx = CB'(idx);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_valid(lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [VPC-1:0] un, input logic sat, input logic conf);
        chk({tag, ".unassign"}, unassign, un);
        chk({tag, ".sat"}, clause_sat, sat);
        chk({tag, ".conflict"}, clause_conflict, conf);
        chk({tag, ".model_unassign"}, cur.un, un);
        chk({tag, ".model_sat"}, cur.sat, sat);
        chk({tag, ".model_conflict"}, cur.conf, conf);
    endtask

    int lat;
    int p0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start_idx = '0; out_ready = 1'b0;
        for (int i = 0; i < NC; i++) begin
            cm[i] = VPC'($urandom);
            cp[i] = VPC'($urandom);
            for (int j = 0; j < VPC; j++) cv[i][j*VB +: VB] = VB'($urandom_range(0, 15));
        end
        for (int v = 0; v < NV; v++) begin
            va[v] = ($urandom_range(0, 3) != 0);
            vv[v] = 1'($urandom_range(0, 1));
        end
        repeat (3) @(negedge clock);
        chk("rst.busy", busy, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.cls_rd_en", cls_rd_en, 0);
        chk("rst.cls_rd_addr", cls_rd_addr, 0);
        chk("rst.var_rd_en", var_rd_en, 0);
        chk("rst.var_rd_addr", var_rd_addr, 0);
        chk("rst.unassign", unassign, 0);
        chk("rst.variable", variable, 0);
        chk("rst.conflict", clause_conflict, 0);
        reset = 1'b0;

        // reset in the middle of SCAN
        @(negedge clock);
        start = 1'b1; start_idx = CB'(3);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t1.busy", busy, 0);
        chk("t1.out_valid", out_valid, 0);
        chk("t1.var_rd_en", var_rd_en, 0);
        chk("t1.cls_rd_en", cls_rd_en, 0);
        chk("t1.mask", clause_mask, 0);
        @(negedge clock);
        reset = 1'b0;
        do_op(3, lat);
        chk("t1.latency", lat, 8);
        handshake();

        cm[7] = 5'b11111; cp[7] = 5'b00000; cv[7] = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int v = 1; v <= 4; v++) begin va[v] = 1'b1; vv[v] = 1'b0; end
        va[5] = 1'b0;
        do_op(7, lat);
        chk("t2.latency", lat, 8);
        chk_res("t2", 5'b10000, 1'b0, 1'b0);
        handshake();

        vv[2] = 1'b1;
        do_op(7, lat);
        chk_res("t3a", 5'b10000, 1'b1, 1'b0);
        handshake();

        cm[8] = 5'b11111; cp[8] = 5'b11111; cv[8] = {8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
        for (int v = 10; v <= 14; v++) begin va[v] = 1'b1; vv[v] = 1'b1; end
        do_op(8, lat);
        chk("t3b.latency", lat, 8);
        chk_res("t3b", 5'b00000, 1'b0, 1'b1);
        handshake();

        // result held under backpressure; a start during the hold is dropped
        vv[2] = 1'b0;
        do_op(7, lat);
        for (int i = 0; i < 5; i++) begin
            start     = (i == 1);
            start_idx = CB'(9);
            @(posedge clock);
            @(negedge clock);
            chk("t5.hold_busy", busy, 1);
            chk("t5.hold_valid", out_valid, 1);
            chk("t5.hold_unassign", unassign, 5'b10000);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("t5.busy_fall", busy, 0);
        chk("t5.valid_fall", out_valid, 0);
        @(negedge clock);
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("t5.start_ignored", busy, 0);

        cm[11] = 5'b11110; cp[11] = 5'b00000; cv[11] = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int v = 1; v <= 5; v++) begin va[v] = 1'b1; vv[v] = 1'b0; end
        va[3] = 1'b0;
        p0 = rd_pulses;
        do_op(11, lat);
        chk("t4.latency", lat, 8);
        chk_res("t4", 5'b00100, 1'b0, 1'b0);
        chk("t4.pulses", rd_pulses - p0, 4);
        handshake();

        // back-to-back: start held high, second clause has an empty mask
        cm[12] = 5'b00000;
        @(negedge clock);
        out_ready = 1'b1; start = 1'b1; start_idx = CB'(7);
        @(posedge clock);
        @(negedge clock);
        start_idx = CB'(12);
        wait_valid(lat);
        chk("t6.latency1", lat, 8);
        @(posedge clock);
        @(negedge clock);
        chk("t6.gap_idle", busy, 0);
        @(posedge clock);
        @(negedge clock);
        chk("t6.second_accept", busy, 1);
        start = 1'b0;
        p0 = rd_pulses;
        wait_valid(lat);
        chk("t6.latency2", lat, 8);
        chk_res("t6", 5'b00000, 1'b0, 1'b0);
        chk("t6.pulses", rd_pulses - p0, 0);
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!busy) begin
                va[$urandom_range(0, 15)] = ($urandom_range(0, 3) != 0);
                vv[$urandom_range(0, 15)] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    p0 = $urandom_range(0, 63);
                    cm[p0] = VPC'($urandom);
                    cp[p0] = VPC'($urandom);
                end
            end
            start     = ($urandom_range(0, 3) == 0);
            start_idx = CB'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clock);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clock);
        chk("end.idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
